contde1_arbitro: RTL
====================

# contde1_arbitro

Round-robin arbiter and sequencer that shares one ones-counting engine (popcount by right shift, early exit on zero) among `N_REQ` requesters. Each requester presents a word and holds `req`. The block grants one requester at a time, loads its word into the engine and runs the count. It then returns the result with a one-cycle `pronto` pulse addressed to that requester. It sits between the client blocks and the counting datapath, which it instantiates.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 16: word width counted.
- `CW`, `$clog2(WIDTH+1)` (5 for 16): result width (derived, not overridable).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: request per requester; level-sensitive.
- `dados` in `N_REQ*WIDTH`: packed words; requester i at `[i*WIDTH +: WIDTH]`.
- `resultado` out `CW`: count of the last completed operation; holds until the next completion.
- `pronto` out `N_REQ`: one-hot, one-cycle completion pulse for the served requester.
- `concedido` out `N_REQ`: one-hot grant. Valid in CONTA and ENTREGA; zero in OCIOSO.
- `ocupado` out 1: high in CONTA and ENTREGA.
- `est` out 2: current state encoding.

## Operation
- States: OCIOSO=2'b00, CONTA=2'b01, ENTREGA=2'b10; 2'b11 is illegal and recovers to OCIOSO.
- OCIOSO:
  - If `req` is zero, stay.
  - Otherwise pick the winner in round-robin order `ptr+1, ptr+2, …` (mod `N_REQ`).
  - On the same edge: latch the grant, load `regA <= dados[winner]`, clear `acc`, go to CONTA.
- CONTA, each cycle:
  - If `regA==0`, go to ENTREGA.
  - Otherwise `acc <= acc + regA[0]` and `regA <= regA >> 1`.
- ENTREGA, on the entry edge:
  - `resultado <= acc` and `pronto[grant] <= 1`.
  - On the next edge: `pronto` clears, `ptr <= grant`, `concedido` clears, go to OCIOSO.
- `dados[winner]` is sampled only at the load edge. Later changes to `dados` have no effect.
- Dropping `req` during CONTA or ENTREGA does not abort the operation. It completes and `pronto` still pulses.
- A requester that keeps `req` high after its `pronto` is re-eligible. Round-robin puts it last.
- Width rule: `acc` is `CW` bits, so overflow is impossible. All-ones 16-bit gives 5'b10000.

## Timing
- Reset values:
  - `est` = 00, `resultado` = 0, `pronto` = 0, `concedido` = 0, `ocupado` = 0.
  - `regA` = 0, `acc` = 0, `ptr` = `N_REQ-1`, so requester 0 wins first.
- Let e be the load edge and h the index of the highest set bit of the word:
  - `pronto` rises at edge e+h+2.
  - For a zero word, `pronto` rises at e+1.
  - Maximum for 16'hFFFF is e+17.
- OCIOSO lasts at least one cycle between operations. Minimum back-to-back period is h+4 cycles.
- `req` seen high at edge e (in OCIOSO) means load at e, with no extra arbitration cycle.
- `reset` asserted mid-operation:
  - Immediate return to reset values.
  - No `pronto` is issued for the aborted request.
  - After deassertion, a still-asserted `req` is re-served from scratch.

## Structure
- Shared package `contde1_pkg`:
  - state localparams OCIOSO, CONTA, ENTREGA;
  - a `CW` helper function computing `$clog2(WIDTH+1)`.
- Sub-module `cont_uns_nucleo`:
  - contains `regA` and `acc` only;
  - inputs `carga`, `passo`, `palavra`;
  - outputs `zero` (`regA==0`) and `acc`.
- The top level holds the FSM, the round-robin pointer and the grant, plus the `pronto`/`resultado` registers.

## Test plan
- Reset check: assert `reset`=0 mid-random traffic. Required: `est`=00 and all outputs 0 within the same cycle. After release, `req`=4'b0001 with `dados[0]`=16'h0001 gives `pronto`=4'b0001 and `resultado`=1.
- Single long word: `req[0]`, 16'hFFFF. Required: `pronto[0]` exactly 17 edges after the load edge, `resultado`=16, `concedido`=4'b0001 throughout.
- Zero word: `req[2]`, 16'h0000. Required: `pronto`=4'b0100 one edge after load, `resultado`=0.
- Fairness: all four `req` held with 16'h0001, 16'h0003, 16'h8000, 16'hA5A5. Required: grant order 0,1,2,3,0; results 1, 2, 1, 8; no requester served twice before the others.
- Withdrawal and data change: load `req[1]` with 16'h00F0, then drop `req[1]` and change `dados[1]` to 16'hFFFF during CONTA. Required: `pronto[1]` still pulses and `resultado`=4.
- Reset mid-count: assert `reset` during CONTA on 16'h8000. Required: no `pronto`, `resultado`=0. After release with `req` held, a full recount gives `resultado`=1.

Source files
------------

// File: rtl/contde1_pkg.sv
// Shared definitions for the ones-counting arbiter: FSM state encoding and
// the result-width helper.
package contde1_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CONTA   = 2'b01,
        ENTREGA = 2'b10,
        ILEGAL  = 2'b11
    } estado_t;

    // Bits needed to hold a count of 0..width set bits.
    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/contde1_arbitro_if.sv
// Bus between the requesting clients (master) and the arbiter (slave).
interface contde1_arbitro_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    localparam int CW = contde1_pkg::cw_of(WIDTH);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] dados;
    logic [CW-1:0]          resultado;
    logic [N_REQ-1:0]       pronto;
    logic [N_REQ-1:0]       concedido;
    logic                   ocupado;
    logic [1:0]             est;

    modport master (
        output req, dados,
        input  resultado, pronto, concedido, ocupado, est
    );

    modport slave (
        input  req, dados,
        output resultado, pronto, concedido, ocupado, est
    );

endinterface

// File: rtl/contde1_arbitro_nucleo.sv
// Counting engine: shifts the loaded word right and accumulates its low bit
// until the word is exhausted.
module cont_uns_nucleo #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic             passo,
    input  logic [WIDTH-1:0] palavra,
    output logic             zero,
    output logic [CW-1:0]    acc
);

    logic [WIDTH-1:0] reg_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_a <= '0;
            acc   <= '0;
        end else if (carga) begin
            reg_a <= palavra;
            acc   <= '0;
        end else if (passo) begin
            acc   <= acc + {{(CW-1){1'b0}}, reg_a[0]};
            reg_a <= reg_a >> 1;
        end
    end

    assign zero = (reg_a == '0);

endmodule

// File: rtl/contde1_arbitro.sv
// Round-robin arbiter that serialises N_REQ clients onto one popcount engine
// and returns each result with a one-cycle pronto pulse to its requester.
module contde1_arbitro
    import contde1_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    contde1_arbitro_if.slave   bus
);

    localparam int CW = cw_of(WIDTH);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    estado_t          est_q, est_d;
    logic [PW-1:0]    ptr, win, win_idx;
    logic [N_REQ-1:0] grant, grant_nxt, pronto_q;
    logic [CW-1:0]    resultado_q, acc;
    logic [WIDTH-1:0] palavra;
    logic             carga, passo, zero;

    // Search starts just after the last served requester, so it goes last.
    always_comb begin
        logic          found;
        logic [PW-1:0] cand;
        int            idx;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(ptr) + k) % N_REQ;
            cand = PW'(idx);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        palavra   = '0;
        grant_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                palavra      = bus.dados[i*WIDTH +: WIDTH];
                grant_nxt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        est_d = est_q;
        carga = 1'b0;
        passo = 1'b0;
        case (est_q)
            OCIOSO: begin
                if (|bus.req) begin
                    carga = 1'b1;
                    est_d = CONTA;
                end
            end
            CONTA: begin
                if (zero) est_d = ENTREGA;
                else      passo = 1'b1;
            end
            ENTREGA: est_d = OCIOSO;
            default: est_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            est_q       <= OCIOSO;
            ptr         <= PW'(N_REQ - 1);
            win_idx     <= '0;
            grant       <= '0;
            pronto_q    <= '0;
            resultado_q <= '0;
        end else begin
            est_q <= est_d;
            case (est_q)
                OCIOSO: begin
                    if (carga) begin
                        grant   <= grant_nxt;
                        win_idx <= win;
                    end
                end
                CONTA: begin
                    if (zero) begin
                        resultado_q <= acc;
                        pronto_q    <= grant;
                    end
                end
                ENTREGA: begin
                    pronto_q <= '0;
                    grant    <= '0;
                    ptr      <= win_idx;
                end
                default: begin
                    pronto_q <= '0;
                    grant    <= '0;
                end
            endcase
        end
    end

    cont_uns_nucleo #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_nucleo (
        .clk     (clk),
        .reset   (reset),
        .carga   (carga),
        .passo   (passo),
        .palavra (palavra),
        .zero    (zero),
        .acc     (acc)
    );

    assign bus.resultado = resultado_q;
    assign bus.pronto    = pronto_q;
    assign bus.concedido = grant;
    assign bus.ocupado   = (est_q == CONTA) || (est_q == ENTREGA);
    assign bus.est       = est_q;

endmodule
